// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the harness UART receiver.
// Optional even-parity support is enabled with UART_RX_PARITY_EN.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } rx_state_e;

    // Bit period in io_clock cycles, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_en_c;
    logic             rd_en_c;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign rd_en_c = pop_i && !empty_o;
    assign wr_en_c = push_i && (!full_o || rd_en_c);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_c) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en_c && !rd_en_c) begin
                count_q <= count_q + CNT_W'(1);
            end else if (rd_en_c && !wr_en_c) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// valid/ready FIFO, with CTS throttled by fill level using hysteresis.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CTS_MARGIN  = 4
) (
    input  logic       io_clock,
    input  logic       io_reset,
    input  logic       io_uart_rxd,
    output logic       io_uart_cts,
    output logic       io_rx_valid,
    input  logic       io_rx_ready,
    output logic [7:0] io_rx_payload,
    output logic       io_frameError,
`ifdef UART_RX_PARITY_EN
    output logic       io_parityError,
`endif
    output logic       io_overrun
);

    localparam int unsigned DIV    = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned DIV_W  = $clog2(DIV + 1);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CTS_HI = FIFO_DEPTH - CTS_MARGIN;
    localparam int unsigned CTS_LO = FIFO_DEPTH / 2;

    rx_state_e            state_q;
    logic                 sync1_q;
    logic                 sync2_q;
    logic                 prev_q;
    logic [DIV_W-1:0]     cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_err_q;
    logic                 overrun_q;
    logic                 cts_q;
    logic                 cts_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q;
    logic                 par_err_q;
`endif

    logic                 tick_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    assign tick_c = (cnt_q == '0);
    assign push_c = (state_q == STOP) && tick_c && sync2_q;
    assign pop_c  = io_rx_valid && io_rx_ready;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk_i   (io_clock),
        .rst_i   (io_reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (shift_q),
        .rdata_o (io_rx_payload),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign io_rx_valid   = !fifo_empty;
    assign io_frameError = frame_err_q;
    assign io_overrun    = overrun_q;
    assign io_uart_cts   = cts_q;
`ifdef UART_RX_PARITY_EN
    assign io_parityError = par_err_q;
`endif

    // Hysteresis: hold CTS between the two thresholds.
    always_comb begin
        cts_d = cts_q;
        if (fifo_count >= CNT_W'(CTS_HI)) begin
            cts_d = 1'b1;
        end else if (fifo_count <= CNT_W'(CTS_LO)) begin
            cts_d = 1'b0;
        end
    end

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            cts_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync1_q     <= io_uart_rxd;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            cts_q       <= cts_d;
            frame_err_q <= 1'b0;
            overrun_q   <= push_c && fifo_full && !pop_c;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= push_c && (par_bit_q != ^shift_q);
`endif
            if (!tick_c) begin
                cnt_q <= cnt_q - DIV_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (prev_q && !sync2_q) begin
                        state_q <= START;
                        cnt_q   <= DIV_W'(DIV / 2 - 1);
                    end
                end
                START: begin
                    if (tick_c) begin
                        if (!sync2_q) begin
                            state_q   <= DATA;
                            cnt_q     <= DIV_W'(DIV - 1);
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick_c) begin
                        shift_q <= {sync2_q, shift_q[DATA_BITS-1:1]};
                        cnt_q   <= DIV_W'(DIV - 1);
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_c) begin
                        par_bit_q <= sync2_q;
                        cnt_q     <= DIV_W'(DIV - 1);
                        state_q   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick_c) begin
                        if (sync2_q) begin
                            state_q <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (sync2_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
